wave_sequencer: RTL and testbench

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

---
 rtl/wave_sequencer.sv | 173 +++++++++++++++++
 tb/tb_wave_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wave_sequencer
// Brief    : Shadow/active configuration sequencer that paces sample requests
//            to a wave datapath with a reloading prescale down-counter.
//            Optional macro WAVE_SEQ_VALID_CHECK_EN enables the sticky
//            missing-valid error flag on err_o.
// Revision : 1.0 - initial release
// ============================================================================
module wave_sequencer #(
    parameter int N_FRAC     = 7,
    parameter int PRESCALE_W = 8,
    localparam int CFG_W     = ((N_FRAC + 1) > PRESCALE_W) ? (N_FRAC + 1) : PRESCALE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     cfg_we_i,
    input  logic [1:0]               cfg_addr_i,
    input  logic [CFG_W-1:0]         cfg_data_i,
    input  logic                     data_valid_i,
    output logic                     next_data_strobe_o,
    output logic signed [N_FRAC:0]   amplitude_o,
    output logic signed [N_FRAC:0]   addend_o,
    output logic                     overflow_mode_o,
    output logic                     running_o,
    output logic                     pending_o,
    output logic                     err_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;

    localparam logic [PRESCALE_W-1:0] c_CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [1:0]              r_state;
    logic [PRESCALE_W-1:0]   r_cnt;
    logic                    r_strobe;
    logic                    r_pending;

    logic signed [N_FRAC:0]  r_sh_amp;
    logic signed [N_FRAC:0]  r_sh_add;
    logic [PRESCALE_W-1:0]   r_sh_pre;
    logic                    r_sh_ovf;

    logic signed [N_FRAC:0]  r_act_amp;
    logic signed [N_FRAC:0]  r_act_add;
    logic [PRESCALE_W-1:0]   r_act_pre;
    logic                    r_act_ovf;

    logic                    w_apply;
    logic                    w_wr_apply;
    logic [PRESCALE_W-1:0]   w_cnt_nxt;

    // An apply copies shadow to active: always in LOAD, on a pending request
    // while idle, or on a returned valid while running.
    always_comb begin
        w_apply = 1'b0;
        case (r_state)
            c_IDLE:  w_apply = r_pending;
            c_LOAD:  w_apply = 1'b1;
            c_RUN:   w_apply = r_pending & data_valid_i;
            default: w_apply = 1'b0;
        endcase
    end

    assign w_wr_apply = cfg_we_i && (cfg_addr_i == 2'd3) && cfg_data_i[1];

    always_comb begin
        w_cnt_nxt = (r_cnt == '0) ? r_act_pre : (r_cnt - c_CNT_ONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_strobe  <= 1'b0;
            r_pending <= 1'b0;
            r_sh_amp  <= '0;
            r_sh_add  <= '0;
            r_sh_pre  <= '0;
            r_sh_ovf  <= 1'b0;
            r_act_amp <= '0;
            r_act_add <= '0;
            r_act_pre <= '0;
            r_act_ovf <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                case (cfg_addr_i)
                    2'd0:    r_sh_amp <= cfg_data_i[N_FRAC:0];
                    2'd1:    r_sh_add <= cfg_data_i[N_FRAC:0];
                    2'd2:    r_sh_pre <= cfg_data_i[PRESCALE_W-1:0];
                    default: r_sh_ovf <= cfg_data_i[0];
                endcase
            end

            // The apply samples the shadow values from before this edge's write.
            if (w_apply) begin
                r_act_amp <= r_sh_amp;
                r_act_add <= r_sh_add;
                r_act_pre <= r_sh_pre;
                r_act_ovf <= r_sh_ovf;
            end

            if (w_wr_apply) begin
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            // The strobe register reflects "cnt reaches zero in RUN" one edge
            // ahead, so the strobe coincides with the zero-count cycle.
            case (r_state)
                c_IDLE: begin
                    r_strobe <= 1'b0;
                    if (enable_i) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_state  <= c_RUN;
                    r_cnt    <= r_sh_pre;
                    r_strobe <= (r_sh_pre == '0);
                end
                c_RUN: begin
                    if (!enable_i) begin
                        r_state  <= c_IDLE;
                        r_strobe <= 1'b0;
                    end else begin
                        r_cnt    <= w_cnt_nxt;
                        r_strobe <= (w_cnt_nxt == '0);
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_strobe <= 1'b0;
                end
            endcase
        end
    end

`ifdef WAVE_SEQ_VALID_CHECK_EN
    logic r_chk;
    logic r_err;

    // Each strobe must be answered by data_valid_i in the following cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_chk <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_chk <= r_strobe;
            if (r_chk && !data_valid_i) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign next_data_strobe_o = r_strobe;
    assign amplitude_o        = r_act_amp;
    assign addend_o           = r_act_add;
    assign overflow_mode_o    = r_act_ovf;
    assign running_o          = (r_state != c_IDLE);
    assign pending_o          = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_sequencer
// Brief    : Scoreboard bench for wave_sequencer; the reference model keeps an
//            absolute-cycle strobe schedule and the shadow/active register sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_sequencer;

    logic              clk;
    logic              rst_i;
    logic              enable_i;
    logic              cfg_we_i;
    logic [1:0]        cfg_addr_i;
    logic [7:0]        cfg_data_i;
    logic              data_valid_i;
    logic              next_data_strobe_o;
    logic signed [7:0] amplitude_o;
    logic signed [7:0] addend_o;
    logic              overflow_mode_o;
    logic              running_o;
    logic              pending_o;
    logic              err_o;

    wave_sequencer #(.N_FRAC(7), .PRESCALE_W(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .enable_i           (enable_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_data_i         (cfg_data_i),
        .data_valid_i       (data_valid_i),
        .next_data_strobe_o (next_data_strobe_o),
        .amplitude_o        (amplitude_o),
        .addend_o           (addend_o),
        .overflow_mode_o    (overflow_mode_o),
        .running_o          (running_o),
        .pending_o          (pending_o),
        .err_o              (err_o)
    );

    typedef struct {
        int c;
        int amp;
        int add;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   obs_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int obs_cnt = 0;
    int dv_drop = 0;
    bit mon_on = 0;

    // Reference model: idle / load / run, with the next strobe held as an
    // absolute cycle number instead of a down-counter.
    int                m_st = 0;
    int                m_next = -1;
    int                m_last_sc = -10;
    bit                m_pend = 0;
    bit                m_err = 0;
    logic signed [7:0] sh_amp = 0, sh_add = 0, ac_amp = 0, ac_add = 0;
    int                sh_pre = 0, ac_pre = 0;
    bit                sh_ovf = 0, ac_ovf = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit strobe_now;
        bit apply;
        int old_ac_pre;
        strobe_now = (m_st == 2) && (m_next == cyc - 1);
        if (!rst_i) begin
            m_st = 0; m_next = -1; m_last_sc = -10; m_pend = 0; m_err = 0;
            sh_amp = 0; sh_add = 0; sh_pre = 0; sh_ovf = 0;
            ac_amp = 0; ac_add = 0; ac_pre = 0; ac_ovf = 0;
            return;
        end
`ifdef WAVE_SEQ_VALID_CHECK_EN
        if (m_last_sc == cyc - 2 && !data_valid_i) m_err = 1;
`endif
        if (strobe_now) m_last_sc = cyc - 1;
        apply = (m_st == 1) || (m_st == 0 && m_pend) || (m_st == 2 && m_pend && data_valid_i);
        old_ac_pre = ac_pre;
        if (apply) begin
            ac_amp = sh_amp; ac_add = sh_add; ac_pre = sh_pre; ac_ovf = sh_ovf;
        end
        if (cfg_we_i && cfg_addr_i == 2'd3 && cfg_data_i[1]) m_pend = 1;
        else if (apply) m_pend = 0;
        if (cfg_we_i) begin
            case (cfg_addr_i)
                2'd0:    sh_amp = cfg_data_i;
                2'd1:    sh_add = cfg_data_i;
                2'd2:    sh_pre = int'(cfg_data_i);
                default: sh_ovf = cfg_data_i[0];
            endcase
        end
        case (m_st)
            0: if (enable_i) m_st = 1;
            1: begin m_st = 2; m_next = cyc + ac_pre; end
            default: begin
                if (!enable_i) m_st = 0;
                else if (strobe_now) m_next = cyc + old_ac_pre;
            end
        endcase
        if (m_st == 2 && m_next == cyc)
            sb.push_back('{cyc, int'(ac_amp), int'(ac_add), int'(ac_ovf)});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we_i   = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        tick();
        cfg_we_i   = 1'b0;
    endtask

    // Datapath stand-in: returns valid one cycle after each strobe unless told to drop it.
    always begin : p_responder
        bit s;
        @(negedge clk);
        s = next_data_strobe_o;
        @(posedge clk);
        #1;
        if (s && dv_drop > 0) begin
            data_valid_i = 1'b0;
            dv_drop--;
        end else begin
            data_valid_i = s;
        end
    end

    always @(negedge clk) begin : p_monitor
        if (mon_on) begin
            if (next_data_strobe_o) begin
                obs_cnt++;
                obs_q.push_back(cyc);
                chk("strobe_expected", 1, int'(sb.size() > 0 && sb[0].c == cyc));
                if (sb.size() > 0 && sb[0].c == cyc) begin
                    mon_e = sb.pop_front();
                    chk("strobe_amplitude", int'(amplitude_o), mon_e.amp);
                    chk("strobe_addend", int'(addend_o), mon_e.add);
                    chk("strobe_ovf", int'(overflow_mode_o), mon_e.ovf);
                end
            end
            while (sb.size() > 0 && sb[0].c <= cyc) begin
                mon_e = sb.pop_front();
                chk("strobe_missing", 0, 1);
            end
            chk("running", int'(running_o), int'(m_st != 0));
            chk("pending", int'(pending_o), int'(m_pend));
            chk("amplitude", int'(amplitude_o), int'(ac_amp));
            chk("addend", int'(addend_o), int'(ac_add));
            chk("overflow_mode", int'(overflow_mode_o), int'(ac_ovf));
            chk("err", int'(err_o), int'(m_err));
        end
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : p_stim
        int load_c;
        int base;
        bit found;
        int exp_err;
        rst_i = 1'b0; enable_i = 1'b0; cfg_we_i = 1'b0;
        cfg_addr_i = 2'd0; cfg_data_i = 8'd0; data_valid_i = 1'b0;
        tick();
        mon_on = 1;
        tick();
        rst_i = 1'b1;
        chk("reset_strobe", int'(next_data_strobe_o), 0);
        chk("reset_running", int'(running_o), 0);
        chk("reset_amplitude", int'(amplitude_o), 0);

        // amp 40, addend 5, prescale 3 -> strobes 4, 8, 12 cycles after LOAD
        cfg_write(2'd0, 8'd40);
        cfg_write(2'd1, 8'd5);
        cfg_write(2'd2, 8'd3);
        obs_q.delete();
        enable_i = 1'b1;
        tick();
        load_c = cyc;
        chk("load_running", int'(running_o), 1);
        repeat (13) tick();
        chk("req026_count", obs_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < obs_q.size()) chk("req026_offset", obs_q[i] - load_c, 4 * (i + 1));
        chk("req026_amp", int'(amplitude_o), 40);
        chk("req026_add", int'(addend_o), 5);

        // staged addend 9 applied on the next returned valid
        cfg_write(2'd1, 8'd9);
        cfg_write(2'd3, 8'h2);
        chk("req027_add_hold", int'(addend_o), 5);
        chk("req027_pending", int'(pending_o), 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = next_data_strobe_o;
        end
        chk("req027_strobe_seen", int'(found), 1);
        chk("req027_add_at_strobe", int'(addend_o), 5);
        tick();
        chk("req027_add_before_valid_edge", int'(addend_o), 5);
        chk("req027_pending_before", int'(pending_o), 1);
        tick();
        chk("req027_add_after", int'(addend_o), 9);
        chk("req027_pending_after", int'(pending_o), 0);

        // idle apply of overflow_mode
        enable_i = 1'b0;
        repeat (2) tick();
        cfg_write(2'd3, 8'h3);
        chk("req031_pending_set", int'(pending_o), 1);
        chk("req031_ovf_hold", int'(overflow_mode_o), 0);
        tick();
        chk("req031_ovf", int'(overflow_mode_o), 1);
        chk("req031_pending_clr", int'(pending_o), 0);

        // prescale 0: strobe every RUN cycle
        cfg_write(2'd2, 8'd0);
        tick();
        base = obs_cnt;
        enable_i = 1'b1;
        tick();
        repeat (5) tick();
        enable_i = 1'b0;
        tick();
        chk("req028_no_strobe_after_stop", int'(next_data_strobe_o), 0);
        tick();
        chk("req028_strobes", obs_cnt - base, 5);
        chk("req028_running", int'(running_o), 0);

        // reset on the zero-count cycle
        cfg_write(2'd2, 8'd3);
        enable_i = 1'b1;
        tick();
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        chk("req029_strobe", int'(next_data_strobe_o), 0);
        chk("req029_amp", int'(amplitude_o), 0);
        chk("req029_add", int'(addend_o), 0);
        chk("req029_ovf", int'(overflow_mode_o), 0);
        chk("req029_running", int'(running_o), 0);
        chk("req029_pending", int'(pending_o), 0);
        rst_i = 1'b1;
        enable_i = 1'b0;
        tick();

        // one unanswered strobe
        cfg_write(2'd2, 8'd2);
        cfg_write(2'd0, 8'd77);
        enable_i = 1'b1;
        tick();
        dv_drop = 1;
        repeat (14) tick();
`ifdef WAVE_SEQ_VALID_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        chk("req030_err", int'(err_o), exp_err);
        enable_i = 1'b0;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 4) enable_i = ~enable_i;
            if ($urandom_range(0, 99) < 25) begin
                cfg_we_i   = 1'b1;
                cfg_addr_i = 2'($urandom_range(0, 3));
                case (cfg_addr_i)
                    2'd2:    cfg_data_i = 8'($urandom_range(0, 5));
                    2'd3:    cfg_data_i = 8'($urandom_range(0, 3));
                    default: cfg_data_i = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 99) < 2) dv_drop = 1;
            if ($urandom_range(0, 299) == 0) rst_i = 1'b0;
            tick();
            cfg_we_i = 1'b0;
            rst_i = 1'b1;
        end

        enable_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
